// File: rtl/noc2_packet_arbiter_pkg.sv
// Shared NoC2 flit geometry: data width and the header MSG_LENGTH field location.
package noc2_packet_arbiter_pkg;

  localparam int unsigned NOC_DATA_WIDTH   = 64;
  localparam int unsigned MSG_LENGTH_WIDTH = 8;
  localparam int unsigned MSG_LENGTH_LO    = 22;
  localparam int unsigned MSG_LENGTH_HI    = MSG_LENGTH_LO + MSG_LENGTH_WIDTH - 1;

endpackage

// File: rtl/noc2_packet_arbiter_if.sv
// Source-side and downstream flit handshake bundle for the NoC2 packet arbiter.
interface noc2_packet_arbiter_if
  import noc2_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
);

  logic [NUM_SRC-1:0]                src_valid_in;
  logic [NUM_SRC*NOC_DATA_WIDTH-1:0] src_data_in;
  logic [NUM_SRC-1:0]                src_ready_out;
  logic                              noc2_valid_out;
  logic [NOC_DATA_WIDTH-1:0]         noc2_data_out;
  logic                              noc2_ready_in;

  // Arbiter side
  modport slave (
    input  src_valid_in, src_data_in, noc2_ready_in,
    output src_ready_out, noc2_valid_out, noc2_data_out
  );

  // Sources plus downstream sink side
  modport master (
    output src_valid_in, src_data_in, noc2_ready_in,
    input  src_ready_out, noc2_valid_out, noc2_data_out
  );

endinterface

// File: rtl/noc2_packet_arbiter_rr_arb_pick.sv
// Round-robin pick: first requesting index strictly after last_grant, wrapping.
module rr_arb_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned GNT_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GNT_W-1:0]   last_grant,
  output logic [GNT_W-1:0]   pick,
  output logic               any
);

  logic             found;
  logic [GNT_W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    // Scan last_grant+1 .. last_grant+NUM_SRC so last_grant itself has lowest priority
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = GNT_W'((32'(last_grant) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc2_packet_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC NoC2 flit sources onto one output.
module noc2_packet_arbiter
  import noc2_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned LEN_W   = MSG_LENGTH_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  noc2_packet_arbiter_if.slave       bus,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned GNT_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [GNT_W-1:0]          grant_q, grant_d;
  logic [GNT_W-1:0]          last_q, last_d;
  logic [LEN_W-1:0]          remaining_q, remaining_d;

  logic [GNT_W-1:0]          pick;
  logic                      any_req;
  logic                      active;
  logic                      sel_valid;
  logic [NOC_DATA_WIDTH-1:0] sel_data;
  logic                      xfer;
  logic [LEN_W-1:0]          hdr_len;

  rr_arb_pick #(
    .NUM_SRC (NUM_SRC),
    .GNT_W   (GNT_W)
  ) u_pick (
    .req        (bus.src_valid_in),
    .last_grant (last_q),
    .pick       (pick),
    .any        (any_req)
  );

  // Combinational passthrough of the granted source while a packet is open
  always_comb begin
    sel_valid         = 1'b0;
    sel_data          = '0;
    bus.src_ready_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GNT_W'(i)) begin
        sel_valid = bus.src_valid_in[i];
        sel_data  = bus.src_data_in[i*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
        bus.src_ready_out[i] = active & bus.noc2_ready_in;
      end
    end
    bus.noc2_valid_out = active & sel_valid;
    bus.noc2_data_out  = active ? sel_data : '0;
  end

  assign active   = (state_q != ST_IDLE);
  assign xfer     = bus.noc2_valid_out & bus.noc2_ready_in;
  assign hdr_len  = sel_data[MSG_LENGTH_LO +: LEN_W];
  assign grant_id = grant_q;
  assign busy     = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= GNT_W'(NUM_SRC - 1);
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state: grant only from IDLE, release on the packet's final transfer
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          remaining_d = hdr_len;
          if (hdr_len == '0) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/noc2_packet_arbiter.md
NOC2_PACKET_ARBITER -- requirements
Module: noc2_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of NoC2 packet sources (2..8).
REQ-002 SHALL have parameter LEN_W, default MSG_LENGTH_WIDTH (8), meaning width of the header length field and the payload counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 SHALL have port src_valid_in, input, NUM_SRC, meaning per-source flit valid.
REQ-006 SHALL have port src_data_in, input, NUM_SRC*NOC_DATA_WIDTH, meaning per-source flit; source i occupies slice i.
REQ-007 SHALL have port src_ready_out, output, NUM_SRC, meaning per-source flit accepted.
REQ-008 SHALL have port noc2_valid_out, output, 1, meaning merged flit valid.
REQ-009 SHALL have port noc2_data_out, output, NOC_DATA_WIDTH, meaning merged flit.
REQ-010 SHALL have port noc2_ready_in, input, 1, meaning downstream ready.
REQ-011 SHALL have port grant_id, output, clog2(NUM_SRC), meaning currently granted source.
REQ-012 SHALL have port busy, output, 1, meaning a packet is in flight (state not IDLE).

Function
REQ-013 SHALL arbitrate packet-atomically: once a header is granted, only that source's flits pass until its last payload flit transfers.
REQ-014 SHALL implement states IDLE, HEADER and BODY.
REQ-015 In IDLE, if any src_valid_in is set, SHALL register grant = round-robin pick and go to HEADER; else remain in IDLE.
REQ-016 Round-robin pick SHALL select the first requesting index strictly after last_grant, wrapping modulo NUM_SRC.
REQ-017 In HEADER and BODY, noc2_valid_out SHALL equal src_valid_in[grant] and noc2_data_out SHALL equal slice grant of src_data_in, with zero-cycle combinational passthrough.
REQ-018 In HEADER and BODY, src_ready_out[grant] SHALL equal noc2_ready_in; all other src_ready_out bits SHALL be 0; in IDLE all bits SHALL be 0.
REQ-019 A transfer SHALL be defined as noc2_valid_out and noc2_ready_in both high in the same cycle.
REQ-020 On a HEADER transfer, the block SHALL capture the header MSG_LENGTH field into remaining.
REQ-021 On a HEADER transfer with length 0, the block SHALL go to IDLE and set last_grant = grant.
REQ-022 On a HEADER transfer with nonzero length, the block SHALL go to BODY.
REQ-023 In BODY, remaining SHALL decrement on each transfer.
REQ-024 On a BODY transfer with remaining == 1, the block SHALL go to IDLE and set last_grant = grant.
REQ-025 Latency: the header SHALL be offered one cycle after the request is seen in IDLE.
REQ-026 Each packet SHALL be followed by one IDLE cycle.
REQ-027 Back-to-back packets from the same source SHALL be allowed only when no other source requests.
REQ-028 A granted source that drops valid mid-packet SHALL stall the arbiter with grant held; no timeout SHALL apply.
REQ-029 A length of 2^LEN_W-1 SHALL be supported without counter wrap.
REQ-030 Requests arriving during HEADER or BODY SHALL have no effect until IDLE.
REQ-031 busy SHALL be 1 exactly when state is not IDLE.

Reset
REQ-032 On rst_n low, the block SHALL set state IDLE, remaining 0, grant 0 and last_grant NUM_SRC-1 asynchronously, so that source 0 wins first.
REQ-033 During reset, noc2_valid_out, src_ready_out and busy SHALL be 0.
REQ-034 Reset mid-packet SHALL abandon the packet; any partial packet downstream is a system-level error and is not recovered.
REQ-035 Reset deassertion SHALL be synchronized externally.

Structure
REQ-036 MSG_LENGTH field position, NOC_DATA_WIDTH and MSG_LENGTH_WIDTH SHALL come from the shared define.tmp.h.
REQ-037 The state encoding SHALL be local to the module.
REQ-038 The round-robin selection SHALL be one combinational sub-module, rr_arb_pick (inputs: request vector, last_grant; outputs: pick, any).

Verification
REQ-039 Directed scenario: single source 2 sends a header with length 2 plus 2 payload flits, noc2_ready_in held 1 -> grant_id=2; 3 flits out on consecutive cycles; busy falls after the 3rd.
REQ-040 Directed scenario: sources 0, 1 and 3 request simultaneously after reset, each sending length-1 packets -> output order 0, 1, 3, 0, ...; no interleaving within a packet.
REQ-041 Directed scenario: source 1 in BODY, noc2_ready_in toggles 1,0,0,1 -> remaining decrements only on ready cycles; noc2_data_out stable while stalled; src_ready_out[1] mirrors ready.
REQ-042 Directed scenario: length-0 header from source 0 with source 1 pending -> 1-flit packet, one IDLE cycle, then source 1 granted.
REQ-043 Directed scenario: rst_n asserted while in BODY with remaining=3 -> state IDLE immediately; all ready/valid 0; first grant after release is source 0.
REQ-044 Directed scenario: header with length 255 -> exactly 256 flits forwarded; no early IDLE.
